// File: rtl/mul_arb_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mul_arb_pkg : shared types for the multiplier-sharing arbiter
// Revision    : 1.0
// ---------------------------------------------------------------------------
package mul_arb_pkg;

  localparam int C_MAX_REQ             = 8;
  localparam int C_REQ_ID_W            = $clog2(C_MAX_REQ);
  localparam int C_DEFAULT_MUL_LATENCY = 2;

  // Sized for the largest supported requester count so any NUM_REQ fits.
  typedef logic [C_REQ_ID_W-1:0] t_req_id;

  typedef struct packed {
    logic    valid;
    t_req_id id;
  } t_tag;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_arbiter : round-robin one-hot arbiter with a rotating last-grant pointer
// Revision   : 1.0
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int PTR_W = $clog2(N);

  logic [PTR_W-1:0] last_grant_q;
  logic [PTR_W-1:0] last_grant_d;
  logic [PTR_W-1:0] start;
  logic [N-1:0]     req_rot;
  logic [N-1:0]     gnt_rot;
  logic [2*N-1:0]   gnt_dbl;
  logic             found;

  // Rotate so the requester after last_grant sits at bit 0, pick the lowest
  // set bit, then rotate the one-hot result back.
  always_comb begin
    start   = (last_grant_q == PTR_W'(N-1)) ? '0 : last_grant_q + PTR_W'(1);
    req_rot = N'({req, req} >> start);
    gnt_rot = '0;
    found   = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (!found && req_rot[j]) begin
        gnt_rot[j] = 1'b1;
        found      = 1'b1;
      end
    end
    gnt_dbl = {{N{1'b0}}, gnt_rot} << start;
    grant   = gnt_dbl[N-1:0] | gnt_dbl[2*N-1:N];

    last_grant_d = last_grant_q;
    if (advance) begin
      for (int i = 0; i < N; i++) begin
        if (grant[i]) last_grant_d = PTR_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) last_grant_q <= PTR_W'(N-1);
    else       last_grant_q <= last_grant_d;
  end

endmodule
`default_nettype wire

// File: rtl/mul_share_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mul_share_arbiter : shares one pipelined multiplier among NUM_REQ requesters
// Revision          : 1.0
// ---------------------------------------------------------------------------
module mul_share_arbiter
  import mul_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_LEN    = 32,
  parameter int MUL_LATENCY = C_DEFAULT_MUL_LATENCY
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               flush,
  input  logic [NUM_REQ-1:0]                 req_valid,
  input  logic [NUM_REQ-1:0][DATA_LEN-1:0]   req_a,
  input  logic [NUM_REQ-1:0][DATA_LEN-1:0]   req_b,
  output logic [NUM_REQ-1:0]                 req_ready,
  output logic [NUM_REQ-1:0]                 rsp_valid,
  output logic [NUM_REQ-1:0][DATA_LEN-1:0]   rsp_result,
  input  logic [NUM_REQ-1:0]                 rsp_ready,
  output logic [DATA_LEN-1:0]                mul_a,
  output logic [DATA_LEN-1:0]                mul_b,
  output logic                               mul_reset,
  input  logic [DATA_LEN-1:0]                mul_result,
  output logic                               idle
);

  logic [NUM_REQ-1:0]               pending_q, pending_d;
  logic [NUM_REQ-1:0]               rsp_valid_q, rsp_valid_d;
  logic [NUM_REQ-1:0][DATA_LEN-1:0] rsp_result_q, rsp_result_d;
  logic [DATA_LEN-1:0]              mul_a_q, mul_a_d;
  logic [DATA_LEN-1:0]              mul_b_q, mul_b_d;
  t_tag [MUL_LATENCY-1:0]           tag_q, tag_d;

  logic [NUM_REQ-1:0] arb_req;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] rsp_hs;
  t_tag               tag_out;
  t_req_id            grant_id;

  // Registered pending keeps a requester out until its response is taken.
  assign arb_req = (reset | flush) ? '0 : (req_valid & ~pending_q);
  assign rsp_hs  = rsp_valid_q & rsp_ready;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr (
    .clk     (clk),
    .reset   (reset),
    .req     (arb_req),
    .advance (|grant),
    .grant   (grant)
  );

  always_comb begin
    grant_id = '0;
    mul_a_d  = '0;
    mul_b_d  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        grant_id = t_req_id'(i);
        mul_a_d  = req_a[i];
        mul_b_d  = req_b[i];
      end
    end

    tag_d          = '0;
    tag_d[0].valid = |grant;
    tag_d[0].id    = grant_id;
    for (int k = 1; k < MUL_LATENCY; k++) begin
      tag_d[k] = tag_q[k-1];
    end

    // A grant never targets a pending id, so set/clear cannot collide.
    pending_d    = (pending_q & ~rsp_hs) | grant;
    rsp_valid_d  = rsp_valid_q & ~rsp_hs;
    rsp_result_d = rsp_result_q;
    tag_out      = tag_q[MUL_LATENCY-1];
    for (int i = 0; i < NUM_REQ; i++) begin
      if (tag_out.valid && (tag_out.id == t_req_id'(i))) begin
        rsp_valid_d[i]  = 1'b1;
        rsp_result_d[i] = mul_result;
      end
    end

    if (flush) begin
      pending_d   = '0;
      rsp_valid_d = '0;
      tag_d       = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q    <= '0;
      rsp_valid_q  <= '0;
      rsp_result_q <= '0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      tag_q        <= '0;
    end else begin
      pending_q    <= pending_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      tag_q        <= tag_d;
    end
  end

  assign req_ready  = grant;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;
  assign mul_reset  = reset | flush;
  assign idle       = ~|pending_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_share_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mul_share_arbiter : scoreboard bench with a behavioural arbitration model
// Revision             : 1.0
// ---------------------------------------------------------------------------
module tb_mul_share_arbiter;

  localparam int N = 4;
  localparam int W = 32;
  localparam int L = 2;

  logic                clk   = 1'b0;
  logic                reset = 1'b1;
  logic                flush = 1'b0;
  logic [N-1:0]        req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N-1:0][W-1:0] req_a, req_b, rsp_result;
  logic [W-1:0]        mul_a, mul_b, mul_result, mpipe;
  logic                mul_reset, idle;

  always #5 clk = ~clk;

  mul_share_arbiter #(
    .NUM_REQ     (N),
    .DATA_LEN    (W),
    .MUL_LATENCY (L)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_result (rsp_result),
    .rsp_ready  (rsp_ready),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_reset  (mul_reset),
    .mul_result (mul_result),
    .idle       (idle)
  );

  // Multiplier: the arbiter's operand register counts as its first stage.
  always @(posedge clk) mpipe <= mul_reset ? '0 : W'(mul_a * mul_b);
  assign mul_result = mpipe;

  typedef struct {
    int           id;
    logic [W-1:0] val;
  } exp_t;

  exp_t         sb[$];
  int           n_pass = 0;
  int           n_total = 0;
  int           cyc = 0;
  int           m_last = N-1;
  logic [N-1:0] m_pending = '0;
  int           m_rcyc[N];
  logic [W-1:0] exp_ma = '0;
  logic [W-1:0] exp_mb = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Flushed or reset in-flight work never comes back.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset || flush) sb.delete();
  end

  // Reference model: pending per requester, round-robin from the last winner.
  always @(negedge clk) begin : model
    int           g;
    logic [N-1:0] rv, hs, exp_rdy;
    exp_t         e;
    if (cyc >= 1) begin
      g = -1;
      if (!reset && !flush) begin
        for (int k = 1; k <= N; k++) begin
          if (g < 0 && req_valid[(m_last + k) % N] && !m_pending[(m_last + k) % N])
            g = (m_last + k) % N;
        end
      end
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      for (int i = 0; i < N; i++) rv[i] = m_pending[i] && (cyc >= m_rcyc[i]);

      chk("req_ready", req_ready, exp_rdy);
      chk("rsp_valid", rsp_valid, rv);
      chk("idle", idle, m_pending == '0);
      chk("mul_a", mul_a, exp_ma);
      chk("mul_b", mul_b, exp_mb);
      chk("mul_reset", mul_reset, reset | flush);

      hs     = rv & rsp_ready;
      exp_ma = '0;
      exp_mb = '0;
      if (reset) begin
        m_pending = '0;
        m_last    = N-1;
      end else if (flush) begin
        m_pending = '0;
      end else begin
        m_pending = m_pending & ~hs;
        if (g >= 0) begin
          m_pending[g] = 1'b1;
          m_rcyc[g]    = cyc + 1 + L;
          m_last       = g;
          exp_ma       = req_a[g];
          exp_mb       = req_b[g];
          e.id         = g;
          e.val        = W'(req_a[g] * req_b[g]);
          sb.push_back(e);
        end
      end
    end
  end

  // Monitor: every presented result must match its queued product.
  always @(negedge clk) begin : monitor
    int k;
    if (cyc >= 1) begin
      for (int i = 0; i < N; i++) begin
        if (rsp_valid[i] === 1'b1) begin
          k = -1;
          for (int j = 0; j < sb.size(); j++) if (k < 0 && sb[j].id == i) k = j;
          if (k < 0) chk("rsp_unexpected", rsp_valid[i], 1'b0);
          else begin
            chk("rsp_result", rsp_result[i], sb[k].val);
            if (rsp_ready[i]) sb.delete(k);
          end
        end
      end
    end
  end

  initial begin
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = '0;
    step(3);
    for (int i = 0; i < N; i++) chk("reset_rsp_result", rsp_result[i], '0);
    reset = 1'b0;

    // Single request held at the response port.
    req_valid[0] = 1'b1; req_a[0] = 7; req_b[0] = 6;
    step(1);
    req_valid = '0;
    step(5);
    chk("single_hold", rsp_result[0], 42);
    step(3);
    rsp_ready[0] = 1'b1;
    step(2);

    // Round-robin from a fresh pointer.
    reset = 1'b1; step(1); reset = 1'b0;
    rsp_ready = '1;
    for (int i = 0; i < N; i++) begin
      req_a[i] = W'(i + 2);
      req_b[i] = 10;
    end
    req_valid = '1;
    step(12);
    req_valid = '0;
    step(6);

    // Truncation, results held for a direct look.
    rsp_ready = '0;
    req_a[0] = 32'h0001_0000; req_b[0] = 32'h0001_0000;
    req_a[1] = 32'hFFFF_FFFF; req_b[1] = 2;
    req_valid = 4'b0011;
    step(2);
    req_valid = '0;
    step(5);
    chk("trunc_valid", rsp_valid[1:0], 2'b11);
    chk("trunc_zero", rsp_result[0], 32'h0);
    chk("trunc_wrap", rsp_result[1], 32'hFFFF_FFFE);
    rsp_ready = '1;
    step(2);

    // Flush one cycle after the second grant.
    req_valid = 4'b0010; req_a[1] = 5; req_b[1] = 5;
    step(1);
    req_valid = 4'b0100; req_a[2] = 4; req_b[2] = 4;
    step(1);
    req_valid = '0;
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    chk("flush_idle", idle, 1'b1);
    req_valid = 4'b0010; req_a[1] = 3; req_b[1] = 3;
    step(1);
    req_valid = '0;
    step(6);

    // Response stall on requester 0 while requester 1 keeps going.
    rsp_ready = 4'b1110;
    req_valid = 4'b0011;
    for (int c = 0; c < 28; c++) begin
      if (c == 20) rsp_ready[0] = 1'b1;
      req_a[0] = $urandom; req_b[0] = $urandom;
      req_a[1] = $urandom; req_b[1] = $urandom;
      step(1);
    end
    req_valid = '0;
    step(6);

    // Reset with three ops in flight.
    rsp_ready = '0;
    for (int i = 0; i < N; i++) begin
      req_a[i] = $urandom;
      req_b[i] = $urandom;
    end
    req_valid = '1;
    step(3);
    reset = 1'b1;
    req_valid = '0;
    step(1);
    chk("rst_mid_rsp_valid", rsp_valid, '0);
    chk("rst_mid_mul_a", mul_a, '0);
    chk("rst_mid_idle", idle, 1'b1);
    chk("rst_mid_req_ready", req_ready, '0);
    reset = 1'b0;
    rsp_ready = '1;
    step(8);

    // Random traffic with occasional flushes.
    for (int c = 0; c < 300; c++) begin
      req_valid = N'($urandom);
      rsp_ready = N'($urandom);
      for (int i = 0; i < N; i++) begin
        req_a[i] = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 15)) : $urandom;
        req_b[i] = $urandom;
      end
      flush = ($urandom_range(0, 39) == 0);
      step(1);
    end
    flush = 1'b0;
    req_valid = '0;
    rsp_ready = '1;
    step(10);
    chk("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
